// File: rtl/pcm_tdm_if.sv
// pcm_tdm_if: frame input handshake and DAC-side pins of the PCM I2S/TDM serializer.
interface pcm_tdm_if #(
  parameter int NUM_CHANNELS = 2,
  parameter int SAMPLE_WIDTH = 16
);
  logic enable;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_data;
  logic sample_valid;
  logic sample_ready;
  logic serial_data_out;
  logic bit_clock_out;
  logic lr_select;
  logic frame_start;
  logic underrun;
  logic underrun_clear;
  modport master (
    output enable, sample_data, sample_valid, underrun_clear,
    input  sample_ready, serial_data_out, bit_clock_out, lr_select, frame_start, underrun
  );
  modport slave (
    input  enable, sample_data, sample_valid, underrun_clear,
    output sample_ready, serial_data_out, bit_clock_out, lr_select, frame_start, underrun
  );
endinterface

// File: rtl/pcm_tdm_serializer.sv
// pcm_tdm_serializer: N-channel PCM to I2S/TDM serializer with divided bit clock, one-frame holding buffer, sticky underrun.
// Define PCM_SER_UNDERRUN_REPEAT_EN to replay the last played frame on underrun instead of silence.
module pcm_tdm_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int CLK_DIV      = 8,
  parameter int I2S_MODE     = 1
) (
  input logic clk,
  input logic reset_active_high,
  pcm_tdm_if.slave bus
);
  localparam int FRAME_BITS = NUM_CHANNELS*SLOT_WIDTH;
  localparam int FW = NUM_CHANNELS*SAMPLE_WIDTH;
  localparam int BW = $clog2(FRAME_BITS);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS-1);
  localparam logic [BW-1:0] DELAY = BW'(I2S_MODE);
  localparam logic [BW-1:0] SLOT1 = BW'(SLOT_WIDTH);
  localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV-1);
  localparam logic [DW-1:0] HALF_DIV = DW'(CLK_DIV/2);
`ifdef PCM_SER_UNDERRUN_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_idx;
  logic [FW-1:0] hold, frame;
  logic hold_full, prev_bit, underrun, frame_start;
  logic boundary, load, xfer, bit_now, tail_bit;
  function automatic logic frame_bit(input logic [FW-1:0] fr, input int p);
    int o;
    o = p % SLOT_WIDTH;
    return o < SAMPLE_WIDTH ? 1'(fr >> ((p / SLOT_WIDTH)*SAMPLE_WIDTH + SAMPLE_WIDTH-1-o)) : 1'b0;
  endfunction
  always_comb begin
    boundary = state == IDLE ? bus.enable : div_cnt == LAST_DIV && bit_idx == LAST_BIT;
    load = boundary && bus.enable;
    state_d = boundary ? (bus.enable ? RUN : IDLE) : state;
    xfer = bus.sample_valid && !hold_full;
    tail_bit = frame_bit(frame, FRAME_BITS-1);
    bit_now = I2S_MODE != 0 && bit_idx == '0 ? prev_bit : frame_bit(frame, int'(bit_idx - DELAY));
  end
  always_ff @(posedge clk or posedge reset_active_high)
    if (reset_active_high) state <= IDLE;
    else state <= state_d;
  // Counters wrap to 0 on their own at the frame boundary, so IDLE entry finds them cleared.
  always_ff @(posedge clk or posedge reset_active_high)
    if (reset_active_high) begin
      div_cnt <= '0;
      bit_idx <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      frame <= '0;
      prev_bit <= 1'b0;
      underrun <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt <= state == IDLE || div_cnt == LAST_DIV ? '0 : div_cnt + 1'b1;
      bit_idx <= state == RUN && div_cnt == LAST_DIV ? (bit_idx == LAST_BIT ? '0 : bit_idx + 1'b1) : bit_idx;
      hold <= xfer ? bus.sample_data : hold;
      hold_full <= xfer || (hold_full && !load);
      frame <= load ? (hold_full ? hold : REPEAT ? frame : '0) : frame;
      prev_bit <= state_d == IDLE ? 1'b0 : load && state == RUN ? tail_bit : prev_bit;
      underrun <= (load && !hold_full) || (underrun && !bus.underrun_clear);
      frame_start <= load;
    end
  assign bus.sample_ready = !hold_full;
  assign bus.bit_clock_out = state == RUN && div_cnt >= HALF_DIV;
  assign bus.lr_select = state == RUN && (NUM_CHANNELS == 2 ? bit_idx >= SLOT1 : bit_idx == '0);
  assign bus.serial_data_out = state == RUN && bit_now;
  assign bus.frame_start = frame_start;
  assign bus.underrun = underrun;
endmodule

// File: tb/tb_pcm_tdm_serializer.sv
// tb_pcm_tdm_serializer: random and directed checks of an I2S (2x32) and a TDM (4x16) serializer against a frame-level model.
module tb_pcm_tdm_serializer;
  logic clk, rst, en, v, clr;
  logic [31:0] da;
  logic [63:0] db;
  int n_chk = 0, n_fail = 0;
  pcm_tdm_if #(.NUM_CHANNELS(2), .SAMPLE_WIDTH(16)) a();
  pcm_tdm_if #(.NUM_CHANNELS(4), .SAMPLE_WIDTH(16)) b();
  assign a.enable = en;
  assign a.sample_valid = v;
  assign a.sample_data = da;
  assign a.underrun_clear = clr;
  assign b.enable = en;
  assign b.sample_valid = v;
  assign b.sample_data = db;
  assign b.underrun_clear = clr;
  pcm_tdm_serializer u_i2s (.clk(clk), .reset_active_high(rst), .bus(a.slave));
  pcm_tdm_serializer #(.SLOT_WIDTH(16), .NUM_CHANNELS(4), .I2S_MODE(0)) u_tdm (.clk(clk), .reset_active_high(rst), .bus(b.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
`ifdef PCM_SER_UNDERRUN_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif
  // Model: d=0 is I2S 2ch x 32-bit slots, d=1 is TDM 4ch x 16-bit slots; both 64 bits x 8 clk per frame.
  logic run[2], hf[2], prev[2], fs[2], ur[2];
  int t[2];
  logic [63:0] hold[2], last[2];
  logic st[2][64];
  task automatic model_reset(input int d);
    run[d] = 0; hf[d] = 0; prev[d] = 0; fs[d] = 0; ur[d] = 0; t[d] = 0;
    hold[d] = '0; last[d] = '0;
    for (int k = 0; k < 64; k++) st[d][k] = 1'b0;
  endtask
  task automatic model_step(input int d);
    logic bnd, ld, hf0;
    logic [63:0] fr, din;
    int nc, slw;
    nc = d ? 4 : 2;
    slw = d ? 16 : 32;
    hf0 = hf[d];
    din = d ? db : {32'h0, da};
    bnd = run[d] ? t[d] == 511 : en;
    ld = bnd && en;
    fs[d] = ld;
    ur[d] = (ld && !hf0) || (ur[d] && !clr);
    if (bnd && !en) begin
      run[d] = 0; t[d] = 0; prev[d] = 0;
    end else if (ld) begin
      if (run[d]) prev[d] = st[d][63];
      if (hf0) last[d] = hold[d];
      fr = hf0 ? hold[d] : REPEAT ? last[d] : 64'h0;
      for (int ch = 0; ch < nc; ch++)
        for (int o = 0; o < slw; o++)
          st[d][ch*slw+o] = o < 16 ? fr[ch*16+15-o] : 1'b0;
      run[d] = 1; t[d] = 0;
    end else if (run[d]) t[d]++;
    if (v && !hf0) begin
      hold[d] = din; hf[d] = 1;
    end else if (ld && hf0) hf[d] = 0;
  endtask
  initial forever begin
    @(posedge clk or posedge rst);
    for (int d = 0; d < 2; d++)
      if (rst) model_reset(d);
      else model_step(d);
  end
  function automatic logic [5:0] exp_out(input int d);
    int bi, dv;
    logic sd;
    bi = t[d] / 8;
    dv = t[d] % 8;
    sd = !run[d] ? 1'b0 : d == 0 ? (bi == 0 ? prev[d] : st[d][bi-1]) : st[d][bi];
    return {sd, run[d] && dv >= 4, run[d] && (d == 0 ? bi >= 32 : bi == 0), fs[d], ur[d], !hf[d]};
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask
  function automatic logic [5:0] out_a();
    return {a.serial_data_out, a.bit_clock_out, a.lr_select, a.frame_start, a.underrun, a.sample_ready};
  endfunction
  function automatic logic [5:0] out_b();
    return {b.serial_data_out, b.bit_clock_out, b.lr_select, b.frame_start, b.underrun, b.sample_ready};
  endfunction
  initial forever begin
    @(negedge clk);
    chk("model_i2s", out_a(), exp_out(0));
    chk("model_tdm", out_b(), exp_out(1));
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_fs();
    int k = 0;
    while (!a.frame_start && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_frame_start", a.frame_start, 1);
  endtask
  // Samples each bit mid-period (bit clock high) starting at the frame_start cycle.
  task automatic collect(output logic [63:0] s0, l0, s1, l1, output logic [7:0] pat);
    s0 = '0; l0 = '0; s1 = '0; l1 = '0; pat = '0;
    for (int c = 0; c < 512; c++) begin
      if (c % 8 == 4) begin
        s0[63-c/8] = a.serial_data_out;
        l0[63-c/8] = a.lr_select;
        s1[63-c/8] = b.serial_data_out;
        l1[63-c/8] = b.lr_select;
      end
      if (c < 8) pat = {pat[6:0], a.bit_clock_out};
      @(negedge clk);
    end
  endtask
  task automatic stream(input int n, output int acc, output int fsn);
    logic x;
    acc = 0; fsn = 0;
    for (int i = 0; i < n; i++) begin
      if (a.frame_start) fsn++;
      x = v && a.sample_ready;
      if (x) acc++;
      @(negedge clk);
      if (x) begin
        da = $urandom;
        db = {$urandom, $urandom};
      end
    end
  endtask
  initial begin
    #600us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [63:0] s0, l0, s1, l1;
    logic [7:0] pat;
    int acc, fsn;
    rst = 1; en = 0; v = 0; clr = 0; da = '0; db = '0;
    cyc(2);
    chk("reset_i2s", out_a(), 6'b000001);
    chk("reset_tdm", out_b(), 6'b000001);
    rst = 0;
    cyc(1);
    da = 32'h3C3C_A5A5;
    db = 64'h8888_4444_2222_1111;
    v = 1;
    cyc(1);
    v = 0;
    chk("push_ready", a.sample_ready, 0);
    en = 1;
    wait_fs();
    collect(s0, l0, s1, l1, pat);
    chk("bclk_pattern", pat, 8'h0F);
    chk("f1_bit0", s0[63], 0);
    chk("f1_ch0", s0[62:47], 16'hA5A5);
    chk("f1_pad0", s0[46:31], 16'h0);
    chk("f1_ch1", s0[30:15], 16'h3C3C);
    chk("f1_lr", l0, 64'h0000_0000_FFFF_FFFF);
    chk("tdm_f1_data", s1, 64'h1111_2222_4444_8888);
    chk("tdm_f1_fsync", l1, 64'h8000_0000_0000_0000);
    chk("frame_period", a.frame_start, 1);
    chk("underrun_set", a.underrun, 1);
    collect(s0, l0, s1, l1, pat);
    chk("f2_bit0", s0[63], 0);
    chk("f2_ch0", s0[62:47], REPEAT ? 64'hA5A5 : 64'h0);
    chk("f2_ch1", s0[30:15], REPEAT ? 64'h3C3C : 64'h0);
    chk("tdm_f2_data", s1, REPEAT ? 64'h1111_2222_4444_8888 : 64'h0);
    clr = 1;
    cyc(1);
    clr = 0;
    chk("underrun_clear_i2s", a.underrun, 0);
    chk("underrun_clear_tdm", b.underrun, 0);
    v = 1;
    da = $urandom;
    db = {$urandom, $urandom};
    stream(511, acc, fsn);
    stream(2048, acc, fsn);
    chk("stream_accepts", 64'(acc), 4);
    chk("stream_frames", 64'(fsn), 4);
    chk("stream_no_underrun", a.underrun, 0);
    stream(1, acc, fsn);
    v = 0;
    cyc(79);
    en = 0;
    cyc(428);
    chk("drop_last_bit_bclk", a.bit_clock_out, 1);
    cyc(4);
    chk("drop_idle_out", out_a(), 6'b000000);
    cyc(8);
    chk("drop_idle_bclk", a.bit_clock_out, 0);
    chk("drop_held", a.sample_ready, 0);
    en = 1;
    cyc(100);
    #3 rst = 1;
    #1;
    chk("async_reset_i2s", out_a(), 6'b000001);
    chk("async_reset_tdm", out_b(), 6'b000001);
    cyc(2);
    rst = 0;
    cyc(1);
    chk("post_reset_fs", a.frame_start, 1);
    chk("post_reset_underrun", a.underrun, 1);
    for (int i = 0; i < 3000; i++) begin
      v = $urandom_range(3) != 0;
      da = $urandom;
      db = {$urandom, $urandom};
      clr = $urandom_range(199) == 0;
      if (i % 257 == 0) en = $urandom_range(3) != 0;
      cyc(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
